// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the clk_tx side of the req/ack CDC handshake.
package cdc_hs_pkg;

    // Handshake phases of the source side.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } hs_state_e;

    // Synchronizer depth: default and legal range.
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low reset.
// Used for hs_ack on the sender; the receiver reuses it for hs_req.
module cdc_sync_bit
    import cdc_hs_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_hs_sender.sv
// Source (clk_tx) end of a 4-phase req/ack multi-bit CDC handshake.
// hs_data is held stable while a handshake is in flight; only the synchronized
// ack is used internally. Optional macro CDC_HS_SKID_EN adds a one-entry pending
// register so the next word can be accepted while a handshake is in flight.
module cdc_hs_sender
    import cdc_hs_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk_tx,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              hs_req,
    output logic [DATA_W-1:0] hs_data,
    input  logic              hs_ack,
    output logic              xfer_done,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_cnt
);

    hs_state_e         r_state, w_state_nxt;
    logic              r_req, w_req_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_done, w_done_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              w_ack_s;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_pend_valid;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (clk_tx),
        .i_rst_n (rst_n),
        .i_d     (hs_ack),
        .o_q     (w_ack_s)
    );

`ifdef CDC_HS_SKID_EN
    logic              r_pend_valid, w_pend_valid_nxt;
    logic [DATA_W-1:0] r_pend_data, w_pend_data_nxt;

    // Pending-entry registers.
    always_ff @(posedge clk_tx or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
        end
    end

    assign w_pend_valid = r_pend_valid;
`else
    assign w_pend_valid = 1'b0;
`endif

    // Ready: in IDLE wait for a stale ack to clear; elsewhere only the skid entry can take a word.
    always_comb begin
        w_in_ready = 1'b0;
        if (r_state == IDLE) begin
            w_in_ready = !w_ack_s;
        end else begin
`ifdef CDC_HS_SKID_EN
            w_in_ready = !r_pend_valid;
`else
            w_in_ready = 1'b0;
`endif
        end
    end

    assign w_accept = in_valid & w_in_ready;

    // Next-state and registered-output logic of the handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
`ifdef CDC_HS_SKID_EN
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
`endif
        case (r_state)
            IDLE: begin
                w_req_nxt = 1'b0;
                if (w_accept) begin
                    w_data_nxt  = in_data;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_req_nxt = 1'b1;
                if (w_ack_s) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = RELEASE;
                end
`ifdef CDC_HS_SKID_EN
                if (w_accept) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_data_nxt  = in_data;
                end
`endif
            end
            RELEASE: begin
                w_req_nxt = 1'b0;
                if (!w_ack_s) begin
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = IDLE;
`ifdef CDC_HS_SKID_EN
                    if (r_pend_valid) begin
                        w_data_nxt       = r_pend_data;
                        w_req_nxt        = 1'b1;
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = REQ;
                    end else if (w_accept) begin
                        // A word accepted on the completing edge launches directly,
                        // keeping the pending entry empty whenever the FSM is in IDLE.
                        w_data_nxt  = in_data;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = REQ;
                    end
`endif
                end
`ifdef CDC_HS_SKID_EN
                else if (w_accept) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_data_nxt  = in_data;
                end
`endif
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_tx or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign hs_req    = r_req;
    assign hs_data   = r_data;
    assign xfer_done = r_done;
    assign xfer_cnt  = r_cnt;
    assign busy      = (r_state != IDLE) | w_pend_valid;

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Self-checking bench for cdc_hs_sender: a behavioural rx-side responder drives
// hs_ack and compares delivered words against an in-order queue of accepted words.
module tb_cdc_hs_sender;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 4;

    logic              clk_tx;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              hs_req;
    logic [DATA_W-1:0] hs_data;
    logic              hs_ack;
    logic              xfer_done;
    logic              busy;
    logic [CNT_W-1:0]  xfer_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] src_q[$];

    cdc_hs_sender #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_tx    (clk_tx),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .hs_req    (hs_req),
        .hs_data   (hs_data),
        .hs_ack    (hs_ack),
        .xfer_done (xfer_done),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    // Upstream model: offers each word of src_q until accepted, then records it as expected.
    task automatic producer(input int max_gap);
        int w;
        while (src_q.size() > 0) begin
            repeat ($urandom_range(0, max_gap)) tick();
            in_valid = 1'b1;
            in_data  = src_q[0];
            w = 0;
            while (in_ready !== 1'b1 && w < 400) begin
                tick();
                w++;
            end
            if (in_ready !== 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL producer_accept: in_ready=%b after %0d cycles, want 1", in_ready, w);
                in_valid = 1'b0;
                return;
            end
            exp_q.push_back(src_q.pop_front());
            tick();
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
        end
    endtask

    // Receiver model: 4-phase responder with random delays, checking data and completion.
    task automatic rx_respond(input int n, input int max_dly);
        logic [DATA_W-1:0] got;
        logic [DATA_W-1:0] exp;
        logic [CNT_W-1:0]  exp_cnt;
        bit snap;
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (hs_req !== 1'b1 && w < 400) begin
                tick();
                w++;
            end
            n_checks++;
            if (hs_req !== 1'b1) begin
                n_fail++;
                $display("FAIL rx_req_wait: hs_req=%b after %0d cycles, want 1", hs_req, w);
                return;
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx_unexpected_req: hs_data=%h with no accepted word", hs_data);
                return;
            end
            exp = exp_q.pop_front();
            got = hs_data;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rx_data: hs_data=%h want %h", got, exp);
            end
            repeat ($urandom_range(0, max_dly)) begin
                tick();
                n_checks++;
                if (hs_data !== got || hs_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rx_hold_req: hs_req=%b hs_data=%h want 1/%h", hs_req, hs_data, got);
                end
            end
            hs_ack = 1'b1;
            w = 0;
            while (hs_req === 1'b1 && w < 50) begin
                tick();
                w++;
                n_checks++;
                if (hs_data !== got) begin
                    n_fail++;
                    $display("FAIL rx_hold_ack: hs_data=%h want %h", hs_data, got);
                end
            end
            n_checks++;
            if (hs_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rx_req_fall: hs_req=%b after %0d cycles, want 0", hs_req, w);
            end
            repeat ($urandom_range(0, max_dly)) begin
                tick();
                n_checks++;
                if (hs_data !== got || hs_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rx_hold_release: hs_req=%b hs_data=%h want 0/%h",
                             hs_req, hs_data, got);
                end
            end
            hs_ack = 1'b0;
            w = 0;
            snap = 1'b0;
            while (xfer_done !== 1'b1 && w < int'(SYNC_STAGES) + 4) begin
                #1;
                snap = (exp_q.size() > 0);
                tick();
                w++;
            end
            n_checks++;
            if (xfer_done !== 1'b1) begin
                n_fail++;
                $display("FAIL rx_done_wait: xfer_done=%b after %0d cycles, want 1", xfer_done, w);
            end
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
            exp_cnt = CNT_W'(model_cnt);
            n_checks++;
            if (xfer_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL rx_xfer_cnt: xfer_cnt=%0d want %0d", xfer_cnt, exp_cnt);
            end
`ifdef CDC_HS_SKID_EN
            n_checks++;
            if (snap) begin
                if (hs_req !== 1'b1 || hs_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rx_skid_reload: hs_req=%b hs_data=%h want 1/%h",
                             hs_req, hs_data, exp_q[0]);
                end
            end else if (hs_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rx_req_gap: hs_req=%b at completion, want 0", hs_req);
            end
`else
            n_checks++;
            if (hs_req !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rx_idle_after_done: hs_req=%b in_ready=%b want 0/1 (snap %0d)",
                         hs_req, in_ready, snap);
            end
`endif
            tick();
            n_checks++;
            if (xfer_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rx_done_width: xfer_done=%b one cycle later, want 0", xfer_done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        hs_ack   = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (hs_req !== 1'b0 || hs_data !== '0 || xfer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b data=%h done=%b want 0/00/0",
                     hs_req, hs_data, xfer_done);
        end
        n_checks++;
        if (busy !== 1'b0 || xfer_cnt !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_status: busy=%b cnt=%0d in_ready=%b want 0/0/1",
                     busy, xfer_cnt, in_ready);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (hs_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: req=%b busy=%b in_ready=%b want 0/0/1",
                     hs_req, busy, in_ready);
        end
        model_cnt = 0;
    endtask

    // Single word A5, with a competing word 3C offered while the handshake is in flight.
    task automatic test_single_word();
        int w;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: in_ready=%b want 1", in_ready);
        end
        exp_q.push_back(8'hA5);
        tick();
        n_checks++;
        if (hs_req !== 1'b1 || hs_data !== 8'hA5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_launch: req=%b data=%h busy=%b want 1/a5/1",
                     hs_req, hs_data, busy);
        end
`ifdef CDC_HS_SKID_EN
        in_valid = 1'b0;
        rx_respond(1, 3);
`else
        in_data = 8'h3C;
        fork
            rx_respond(1, 3);
            begin
                w = 0;
                while (hs_ack !== 1'b1 && w < 100) begin
                    n_checks++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stable_ready_req: in_ready=%b want 0", in_ready);
                    end
                    tick();
                    w++;
                end
                while (hs_ack === 1'b1 && w < 200) begin
                    n_checks++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stable_ready_ack: in_ready=%b want 0", in_ready);
                    end
                    tick();
                    w++;
                end
                in_valid = 1'b0;
            end
        join
`endif
        n_checks++;
        if (xfer_cnt !== CNT_W'(1) || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: cnt=%0d in_ready=%b busy=%b want 1/1/0",
                     xfer_cnt, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        src_q.push_back(8'h11);
        src_q.push_back(8'h22);
`ifdef CDC_HS_SKID_EN
        src_q.push_back(8'h33);
        fork
            producer(0);
            rx_respond(3, 2);
        join
`else
        fork
            producer(0);
            rx_respond(2, 2);
        join
`endif
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: %0d words undelivered, busy=%b want 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) src_q.push_back(DATA_W'($urandom));
        fork
            producer(3);
            rx_respond(20, 4);
        join
        n_checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: %0d words undelivered, busy=%b want 0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_stale_ack();
        hs_ack = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        in_valid = 1'b1;
        in_data  = 8'hC3;
        repeat (5) begin
            tick();
            n_checks++;
            if (hs_req !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_block: req=%b in_ready=%b want 0/0", hs_req, in_ready);
            end
        end
        hs_ack = 1'b0;
        for (int k = 0; k < int'(SYNC_STAGES); k++) begin
            tick();
            n_checks++;
            if (hs_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_early: hs_req=%b %0d cycles after ack drop, want 0", hs_req, k + 1);
            end
        end
        exp_q.push_back(8'hC3);
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (hs_req !== 1'b1 || hs_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL stale_accept: req=%b data=%h want 1/c3", hs_req, hs_data);
        end
        rx_respond(1, 2);
    endtask

    task automatic test_reset_mid();
        int w;
        in_valid = 1'b1;
        in_data  = 8'h77;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (hs_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup: hs_req=%b want 1", hs_req);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (hs_req !== 1'b0 || hs_data !== '0 || busy !== 1'b0 || xfer_cnt !== '0 ||
            xfer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: req=%b data=%h busy=%b cnt=%0d done=%b want 0/00/0/0/0",
                     hs_req, hs_data, busy, xfer_cnt, xfer_done);
        end
        exp_q.delete();
        model_cnt = 0;
        hs_ack = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        src_q.push_back(8'h5A);
        fork
            producer(1);
            rx_respond(1, 2);
        join
        n_checks++;
        if (xfer_cnt !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL midrst_after: xfer_cnt=%0d want 1", xfer_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random();
        test_stale_ack();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
